seg_char_scroller: RTL and testbench

SEG_CHAR_SCROLLER -- requirements
Module: seg_char_scroller

---
 rtl/seg_char_scroller.sv | 239 +++++++++++++++++++++++
 tb/tb_seg_char_scroller.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_char_scroller.sv
// seg_char_scroller: scrolls a written ASCII message across NUM_DIGITS 7-segment digits; SEG_PAUSE_BLINK_EN blinks the frame while paused.
// Latency: o_Len/o_Full one cycle after a write or clear; o_Segments one cycle after any head/len/buffer change.
// Backpressure: none; a write while full, or together with i_Clear, is dropped.
module seg_char_scroller #(
    parameter int NUM_DIGITS    = 2,
    parameter int MSG_DEPTH     = 16,
    parameter int CLKS_PER_STEP = 12500000,
    parameter int DEBOUNCE_CLKS = 250000
) (
    input  logic                             i_Clk,
    input  logic                             i_Rst_L,
    input  logic                             i_Wr_En,
    input  logic [7:0]                       i_Wr_Char,
    input  logic                             i_Clear,
    input  logic                             i_Switch,
    output logic [7*NUM_DIGITS-1:0]          o_Segments,
    output logic [$clog2(MSG_DEPTH+1)-1:0]   o_Len,
    output logic                             o_Full
);

    localparam int LW = $clog2(MSG_DEPTH + 1);
    localparam int IW = $clog2(MSG_DEPTH);
    localparam int SW = (CLKS_PER_STEP > 1) ? $clog2(CLKS_PER_STEP) : 1;
    localparam int DW = (DEBOUNCE_CLKS > 1) ? $clog2(DEBOUNCE_CLKS) : 1;
    localparam logic [SW-1:0] STEP_LAST = SW'(CLKS_PER_STEP - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CLKS - 1);

    typedef enum logic [1:0] {IDLE, STATIC, SCROLL, PAUSE} state_t;

    state_t                  state_q;
    state_t                  next_state;
    logic [1:0]              rst_pipe;
    logic                    rst_n;
    logic                    sw_meta;
    logic                    sw_sync;
    logic                    deb_level;
    logic [DW-1:0]           deb_cnt;
    logic                    run;
    logic [7:0]              buffer [MSG_DEPTH];
    logic [LW-1:0]           len_q;
    logic                    full_q;
    logic                    wr_ok;
    logic [IW-1:0]           head_q;
    logic [IW-1:0]           head_inc;
    logic [SW-1:0]           step_q;
    logic                    frame_blank;
    logic [LW:0]             pos;
    logic [7*NUM_DIGITS-1:0] seg_next;
    logic [7*NUM_DIGITS-1:0] seg_q;

    // Assertion is immediate; release is retimed so every state flop leaves reset on a clean edge.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            rst_pipe <= '0;
        end else begin
            rst_pipe <= {rst_pipe[0], 1'b1};
        end
    end

    assign rst_n = rst_pipe[1];

    always_ff @(posedge i_Clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta   <= 1'b0;
            sw_sync   <= 1'b0;
            deb_level <= 1'b0;
            deb_cnt   <= '0;
            run       <= 1'b1;
        end else begin
            sw_meta <= i_Switch;
            sw_sync <= sw_meta;
            if (sw_sync == deb_level) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                deb_cnt   <= '0;
                deb_level <= sw_sync;
                if (sw_sync) begin
                    run <= ~run;
                end
            end else begin
                deb_cnt <= deb_cnt + DW'(1);
            end
        end
    end

    assign wr_ok = i_Wr_En && !i_Clear && !full_q;

    always_ff @(posedge i_Clk) begin
        if (wr_ok) begin
            buffer[len_q[IW-1:0]] <= i_Wr_Char;
        end
    end

    always_ff @(posedge i_Clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q  <= '0;
            full_q <= 1'b0;
        end else if (i_Clear) begin
            len_q  <= '0;
            full_q <= 1'b0;
        end else if (wr_ok) begin
            len_q  <= len_q + LW'(1);
            full_q <= (len_q == LW'(MSG_DEPTH - 1));
        end
    end

    always_comb begin
        next_state = IDLE;
        if (len_q == '0) begin
            next_state = IDLE;
        end else if (int'(len_q) <= NUM_DIGITS) begin
            next_state = STATIC;
        end else if (run) begin
            next_state = SCROLL;
        end else begin
            next_state = PAUSE;
        end
    end

    always_ff @(posedge i_Clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= next_state;
        end
    end

    // The >= form also lands on 0 when a clear has just emptied the message.
    assign head_inc = (int'(head_q) + 1 >= int'(len_q)) ? '0 : head_q + IW'(1);

    always_ff @(posedge i_Clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            step_q <= '0;
        end else if (i_Clear) begin
            head_q <= '0;
            step_q <= '0;
        end else begin
            case (state_q)
                SCROLL: begin
                    if (step_q == STEP_LAST) begin
                        step_q <= '0;
                        head_q <= head_inc;
                    end else begin
                        step_q <= step_q + SW'(1);
                    end
                end
                PAUSE: begin
                    if (next_state == SCROLL) begin
                        step_q <= '0;
                    end
                end
                default: begin
                    head_q <= '0;
                    step_q <= '0;
                end
            endcase
        end
    end

`ifdef SEG_PAUSE_BLINK_EN
    logic [SW-1:0] blink_cnt;
    logic          blink_off;

    always_ff @(posedge i_Clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt <= '0;
            blink_off <= 1'b0;
        end else if (state_q != PAUSE) begin
            blink_cnt <= '0;
            blink_off <= 1'b0;
        end else if (blink_cnt == STEP_LAST) begin
            blink_cnt <= '0;
            blink_off <= ~blink_off;
        end else begin
            blink_cnt <= blink_cnt + SW'(1);
        end
    end

    assign frame_blank = (state_q == PAUSE) && blink_off;
`else
    assign frame_blank = 1'b0;
`endif

    // Active-high gfedcba pattern, inverted on return; anything not listed is blank.
    function automatic logic [6:0] glyph(input logic [7:0] c);
        logic [6:0] on;
        on = 7'h00;
        case (c)
            "0": on = 7'h3F;  "1": on = 7'h06;  "2": on = 7'h5B;  "3": on = 7'h4F;
            "4": on = 7'h66;  "5": on = 7'h6D;  "6": on = 7'h7D;  "7": on = 7'h07;
            "8": on = 7'h7F;  "9": on = 7'h6F;
            "A": on = 7'h77;  "B": on = 7'h7F;  "C": on = 7'h39;  "D": on = 7'h3F;
            "E": on = 7'h79;  "F": on = 7'h71;  "G": on = 7'h3D;  "H": on = 7'h76;
            "I": on = 7'h30;  "J": on = 7'h1E;  "K": on = 7'h75;  "L": on = 7'h38;
            "M": on = 7'h37;  "N": on = 7'h37;  "O": on = 7'h3F;  "P": on = 7'h73;
            "Q": on = 7'h67;  "R": on = 7'h50;  "S": on = 7'h6D;  "T": on = 7'h78;
            "U": on = 7'h3E;  "V": on = 7'h3E;  "W": on = 7'h7E;  "X": on = 7'h76;
            "Y": on = 7'h6E;  "Z": on = 7'h5B;
            "a": on = 7'h5F;  "b": on = 7'h7C;  "c": on = 7'h58;  "d": on = 7'h5E;
            "e": on = 7'h7B;  "f": on = 7'h71;  "g": on = 7'h6F;  "h": on = 7'h74;
            "i": on = 7'h10;  "j": on = 7'h0E;  "k": on = 7'h75;  "l": on = 7'h30;
            "m": on = 7'h54;  "n": on = 7'h54;  "o": on = 7'h5C;  "p": on = 7'h73;
            "q": on = 7'h67;  "r": on = 7'h50;  "s": on = 7'h6D;  "t": on = 7'h78;
            "u": on = 7'h1C;  "v": on = 7'h1C;  "w": on = 7'h1C;  "x": on = 7'h76;
            "y": on = 7'h6E;  "z": on = 7'h5B;
            "-": on = 7'h40;  " ": on = 7'h00;
            default: on = 7'h00;
        endcase
        return ~on;
    endfunction

    always_comb begin
        seg_next = '1;
        pos      = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            pos = (LW+1)'(head_q) + (LW+1)'(k);
            if (pos >= {1'b0, len_q}) begin
                pos = pos - {1'b0, len_q};
            end
            if ((k < int'(len_q)) && !frame_blank) begin
                seg_next[7*k +: 7] = glyph(buffer[pos[IW-1:0]]);
            end
        end
    end

    always_ff @(posedge i_Clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q <= '1;
        end else begin
            seg_q <= seg_next;
        end
    end

    assign o_Segments = seg_q;
    assign o_Len      = len_q;
    assign o_Full     = full_q;

endmodule

// File: tb/tb_seg_char_scroller.sv
// Scoreboard bench for seg_char_scroller: a message-level model predicts every post-edge output.
module tb_seg_char_scroller;

    localparam int ND    = 2;
    localparam int DEPTH = 4;
    localparam int CPS   = 4;
    localparam int DEB   = 3;
    localparam int LW    = $clog2(DEPTH + 1);
    localparam int S_IDLE = 0, S_STATIC = 1, S_SCROLL = 2, S_PAUSE = 3;

    logic              i_Clk = 1'b0;
    logic              i_Rst_L = 1'b1;
    logic              i_Wr_En = 1'b0;
    logic [7:0]        i_Wr_Char = 8'h00;
    logic              i_Clear = 1'b0;
    logic              i_Switch = 1'b0;
    logic [7*ND-1:0]   o_Segments;
    logic [LW-1:0]     o_Len;
    logic              o_Full;

    seg_char_scroller #(
        .NUM_DIGITS(ND), .MSG_DEPTH(DEPTH), .CLKS_PER_STEP(CPS), .DEBOUNCE_CLKS(DEB)
    ) dut (
        .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Wr_En(i_Wr_En), .i_Wr_Char(i_Wr_Char),
        .i_Clear(i_Clear), .i_Switch(i_Switch), .o_Segments(o_Segments),
        .o_Len(o_Len), .o_Full(o_Full)
    );

    always #5 i_Clk = ~i_Clk;

    typedef struct packed {
        logic [7*ND-1:0] seg;
        logic [LW-1:0]   len;
        logic            full;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;

    logic [6:0] dig_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    logic [6:0] up_tab [26] = '{7'h77, 7'h7F, 7'h39, 7'h3F, 7'h79, 7'h71, 7'h3D, 7'h76, 7'h30, 7'h1E,
                                7'h75, 7'h38, 7'h37, 7'h37, 7'h3F, 7'h73, 7'h67, 7'h50, 7'h6D, 7'h78,
                                7'h3E, 7'h3E, 7'h7E, 7'h76, 7'h6E, 7'h5B};
    logic [6:0] lo_tab [26] = '{7'h5F, 7'h7C, 7'h58, 7'h5E, 7'h7B, 7'h71, 7'h6F, 7'h74, 7'h10, 7'h0E,
                                7'h75, 7'h30, 7'h54, 7'h54, 7'h5C, 7'h73, 7'h67, 7'h50, 7'h6D, 7'h78,
                                7'h1C, 7'h1C, 7'h1C, 7'h76, 7'h6E, 7'h5B};

    // Model state: the message as a queue, the scroll position and a sample history for the button.
    logic [7:0] msg[$];
    int         m_head, m_step, m_pcyc, m_state;
    bit         m_run, m_level;
    bit         raw_q[$];
    bit         hist[$];
    bit         sw_level;

    function automatic logic [6:0] glyph_of(input logic [7:0] c);
        int v;
        v = int'(c);
        if (v >= 48 && v <= 57)  return ~dig_tab[v - 48];
        if (v >= 65 && v <= 90)  return ~up_tab[v - 65];
        if (v >= 97 && v <= 122) return ~lo_tab[v - 97];
        if (v == 45)             return ~7'h40;
        return 7'h7F;
    endfunction

    function automatic int classify(input int len, input bit run_f);
        if (len == 0)  return S_IDLE;
        if (len <= ND) return S_STATIC;
        return run_f ? S_SCROLL : S_PAUSE;
    endfunction

    task automatic model_reset();
        msg.delete();
        raw_q.delete();
        hist.delete();
        raw_q.push_back(1'b0);
        raw_q.push_back(1'b0);
        m_head = 0; m_step = 0; m_pcyc = 0; m_state = S_IDLE;
        m_run = 1'b1; m_level = 1'b0;
    endtask

    task automatic model_step(input bit wr, input logic [7:0] ch, input bit clr, input bit sw);
        int   len0;
        int   ns;
        bit   s;
        bit   all_diff;
        exp_t e;
        len0  = msg.size();
        e.seg = '1;
        for (int k = 0; k < ND; k++) begin
            if (k < len0) e.seg[7*k +: 7] = glyph_of(msg[(m_head + k) % len0]);
        end
`ifdef SEG_PAUSE_BLINK_EN
        if (m_state == S_PAUSE && ((m_pcyc / CPS) % 2) == 1) e.seg = '1;
`endif
        ns = classify(len0, m_run);
        if (clr) begin
            m_head = 0; m_step = 0;
        end else if (m_state == S_SCROLL) begin
            m_step++;
            if (m_step == CPS) begin
                m_step = 0;
                m_head = (len0 == 0) ? 0 : (m_head + 1) % len0;
            end
        end else if (m_state == S_PAUSE) begin
            if (ns == S_SCROLL) m_step = 0;
        end else begin
            m_head = 0; m_step = 0;
        end
        m_pcyc = (m_state == S_PAUSE) ? m_pcyc + 1 : 0;
        if (clr) msg.delete();
        else if (wr && msg.size() < DEPTH) msg.push_back(ch);
        s = raw_q.pop_front();
        raw_q.push_back(sw);
        hist.push_back(s);
        if (hist.size() > DEB) void'(hist.pop_front());
        if (hist.size() == DEB) begin
            all_diff = 1'b1;
            foreach (hist[i]) if (hist[i] == m_level) all_diff = 1'b0;
            if (all_diff) begin
                m_level = !m_level;
                if (m_level) m_run = !m_run;
            end
        end
        m_state = ns;
        e.len  = LW'(msg.size());
        e.full = (msg.size() == DEPTH);
        exp_q.push_back(e);
    endtask

    task automatic cyc(input bit wr, input logic [7:0] ch, input bit clr, input bit sw);
        i_Wr_En = wr; i_Wr_Char = ch; i_Clear = clr; i_Switch = sw;
        @(posedge i_Clk);
        model_step(wr, ch, clr, sw);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 8'h00, 1'b0, sw_level);
    endtask

    task automatic write_str(input string s);
        for (int i = 0; i < s.len(); i++) cyc(1'b1, s[i], 1'b0, sw_level);
    endtask

    task automatic rand_cycle();
        bit         wr, clr;
        logic [7:0] ch;
        if ($urandom_range(0, 19) == 0) sw_level = !sw_level;
        clr = ($urandom_range(0, 39) == 0);
        wr  = ($urandom_range(0, 3) == 0);
        ch  = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(32, 126));
        cyc(wr, ch, clr, sw_level);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) $display("FAIL %s: got %h, expected %h", name, act, req);
        else passes++;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge i_Clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                if (o_Segments !== e.seg || o_Len !== e.len || o_Full !== e.full)
                    $display("FAIL scoreboard t=%0t: got seg=%h len=%0d full=%0b, expected seg=%h len=%0d full=%0b",
                             $time, o_Segments, o_Len, o_Full, e.seg, e.len, e.full);
                else
                    passes++;
            end
        end
    end

    initial begin : stimulus
        model_reset();
        sw_level = 1'b0;
        #1 i_Rst_L = 1'b0;
        @(posedge i_Clk);
        @(negedge i_Clk);
        chk("reset_seg", 32'(o_Segments), 32'(14'h3FFF));
        chk("reset_len", 32'(o_Len), 32'd0);
        chk("reset_full", 32'(o_Full), 32'd0);
        @(posedge i_Clk);
        #1 i_Rst_L = 1'b1;
        idle(3);

        // Static two-character frame.
        write_str("1H");
        idle(20);

        // Full message scrolls; fifth write is dropped.
        cyc(1'b0, 8'h00, 1'b1, sw_level);
        write_str("0123");
        idle(10);
        cyc(1'b1, "5", 1'b0, sw_level);
        idle(12);

        // Bouncy press pauses exactly once, release does nothing, second press resumes.
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        sw_level = 1'b1;
        idle(6);
        idle(20);
        sw_level = 1'b0;
        idle(10);
        sw_level = 1'b1;
        idle(8);
        idle(10);
        sw_level = 1'b0;
        idle(6);

        // Clear wins over a simultaneous write.
        cyc(1'b1, "7", 1'b1, sw_level);
        idle(4);

        // Unmapped code and lower-case glyphs.
        cyc(1'b1, 8'h7E, 1'b0, sw_level);
        write_str("b");
        idle(6);
        cyc(1'b0, 8'h00, 1'b1, sw_level);
        write_str("n-d ");
        idle(12);
        cyc(1'b0, 8'h00, 1'b1, sw_level);

        repeat (1500) rand_cycle();

        // Get into a running scroll, then pull reset between edges.
        sw_level = 1'b0;
        idle(6);
        if (!m_run) begin
            sw_level = 1'b1;
            idle(6);
            sw_level = 1'b0;
            idle(6);
        end
        cyc(1'b0, 8'h00, 1'b1, sw_level);
        write_str("0123");
        idle(6);
        @(negedge i_Clk);
        #1;
        i_Wr_En = 1'b0; i_Clear = 1'b0; i_Switch = 1'b0;
        i_Rst_L = 1'b0;
        #1;
        chk("async_rst_seg", 32'(o_Segments), 32'(14'h3FFF));
        chk("async_rst_len", 32'(o_Len), 32'd0);
        chk("async_rst_full", 32'(o_Full), 32'd0);
        model_reset();
        sw_level = 1'b0;
        @(posedge i_Clk);
        @(posedge i_Clk);
        #1 i_Rst_L = 1'b1;
        idle(3);
        write_str("Ab-9");
        idle(20);
        repeat (300) rand_cycle();

        @(negedge i_Clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
